// File: rtl/mdr_pkg.sv
// Shared types for the MDR host sequencer: command opcodes, response status codes and FSM states.
package mdr_pkg;

  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    OP_MULT,
    OP_DIV,
    OP_SQRT,
    OP_ILLEGAL
  } mdr_op_e;

  typedef enum logic [1:0] {
    ST_OK,
    ST_MDR_ERR,
    ST_TIMEOUT,
    ST_ILLEGAL
  } mdr_status_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD_X,
    GAP_X,
    LOAD_Y,
    WAIT_RDY,
    RESP
  } seq_state_e;

endpackage

// File: rtl/mdr_seq_timeout.sv
// Saturating wait-state counter: clear has priority over enable, expired when it reaches TimeoutCyc-1.
module mdr_seq_timeout #(
  parameter int unsigned TimeoutCyc = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TimeoutCyc);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCyc - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mdr_host_sequencer.sv
// Requester side of the MDR operand-load protocol: one command in flight, loads X then Y,
// waits for a fresh Ready edge and returns result/reminder with a status.
module mdr_host_sequencer #(
  parameter int unsigned DW          = mdr_pkg::DW,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_x,
  input  logic [DW-1:0] cmd_y,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_result,
  output logic [DW-1:0] rsp_reminder,
  output logic [1:0]    rsp_status,
  output logic          busy,
  output logic          mdr_start,
  output logic          mdr_load,
  output logic [1:0]    mdr_op,
  output logic [DW-1:0] mdr_data,
  input  logic          mdr_load_x,
  input  logic          mdr_load_y,
  input  logic          mdr_ready,
  input  logic          mdr_error,
  input  logic [DW-1:0] mdr_result,
  input  logic [DW-1:0] mdr_reminder
);

  import mdr_pkg::*;

  seq_state_e    state_q, state_d;
  mdr_op_e       op_q, op_d;
  mdr_status_e   status_q, status_d;
  logic [DW-1:0] x_q, x_d, y_q, y_d;
  logic [DW-1:0] result_q, result_d, rem_q, rem_d;
  logic          rdy_prev_q, rdy_prev_d;
  logic          rdy_rise;
  logic          tmo_clr, tmo_en, tmo_expired;

  assign rdy_rise = mdr_ready & ~rdy_prev_q;
  // Armed with the current Ready sample on entry so a stale sticky Ready is never an edge.
  assign rdy_prev_d = (state_d == WAIT_RDY) ? mdr_ready : 1'b0;

  assign tmo_clr = (state_d != state_q);
  assign tmo_en  = (state_q == LOAD_X) || (state_q == LOAD_Y) || (state_q == WAIT_RDY);

  mdr_seq_timeout #(
    .TimeoutCyc(TIMEOUT_CYC)
  ) u_timeout (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expired_o(tmo_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= OP_MULT;
      status_q   <= ST_OK;
      x_q        <= '0;
      y_q        <= '0;
      result_q   <= '0;
      rem_q      <= '0;
      rdy_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      status_q   <= status_d;
      x_q        <= x_d;
      y_q        <= y_d;
      result_q   <= result_d;
      rem_q      <= rem_d;
      rdy_prev_q <= rdy_prev_d;
    end
  end

  // Priority in every wait state: MDR error, then ack/Ready, then timeout.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    status_d = status_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    rem_d    = rem_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d     = mdr_op_e'(cmd_op);
          x_d      = cmd_x;
          y_d      = cmd_y;
          result_d = '0;
          rem_d    = '0;
          status_d = ST_OK;
          if (mdr_op_e'(cmd_op) == OP_ILLEGAL) begin
            status_d = ST_ILLEGAL;
            state_d  = RESP;
          end else begin
            state_d = START;
          end
        end
      end
      START: state_d = LOAD_X;
      LOAD_X: begin
        if (mdr_error) begin
          status_d = ST_MDR_ERR;
          state_d  = RESP;
        end else if (mdr_load_x) begin
          state_d = GAP_X;
        end else if (tmo_expired) begin
          status_d = ST_TIMEOUT;
          state_d  = RESP;
        end
      end
      GAP_X: begin
        if (mdr_error) begin
          status_d = ST_MDR_ERR;
          state_d  = RESP;
        end else begin
          state_d = LOAD_Y;
        end
      end
      LOAD_Y: begin
        if (mdr_error) begin
          status_d = ST_MDR_ERR;
          state_d  = RESP;
        end else if (mdr_load_y) begin
          state_d = WAIT_RDY;
        end else if (tmo_expired) begin
          status_d = ST_TIMEOUT;
          state_d  = RESP;
        end
      end
      WAIT_RDY: begin
        if (mdr_error) begin
          status_d = ST_MDR_ERR;
          state_d  = RESP;
        end else if (rdy_rise) begin
          result_d = mdr_result;
          rem_d    = mdr_reminder;
          status_d = ST_OK;
          state_d  = RESP;
        end else if (tmo_expired) begin
          status_d = ST_TIMEOUT;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == RESP);
    mdr_start = (state_q == START);
    mdr_load  = (state_q == LOAD_X) || (state_q == LOAD_Y);
    mdr_op    = 2'b00;
    mdr_data  = '0;
    if (state_q != IDLE && op_q != OP_ILLEGAL) begin
      mdr_op = op_q;
    end
    case (state_q)
      LOAD_X, GAP_X: mdr_data = x_q;
      LOAD_Y:        mdr_data = (op_q == OP_SQRT) ? '0 : y_q;
      default:       mdr_data = '0;
    endcase
  end

  assign rsp_result   = result_q;
  assign rsp_reminder = rem_q;
  assign rsp_status   = status_q;

endmodule
